// File: rtl/smooth_pkg.sv
// Shared types and constant helpers for the row smoothing filter.
package smooth_pkg;

    typedef enum logic {
        ROW_START = 1'b0,
        IN_ROW    = 1'b1
    } smooth_state_e;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/smooth_tap_line.sv
// TAPS-deep pixel delay line; fill_i loads every slot with din_i, shift_i pushes din_i in.
module smooth_tap_line #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] oldest_o
);

    logic [DATA_W-1:0] tap_q [TAPS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else if (fill_i) begin
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= din_i;
            end
        end else if (shift_i) begin
            tap_q[0] <= din_i;
            for (int i = 1; i < TAPS; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign oldest_o = tap_q[TAPS-1];

endmodule

// File: rtl/row_smoothing_filter.sv
// Per-row moving-average filter with edge clamp at column 0 and a running-sum datapath.
// Define SMOOTH_ROUND_EN to round the mean half up instead of truncating.
module row_smoothing_filter
    import smooth_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 4,
    parameter int ROW_LEN = 150
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int LOG2_T = clog2_f(TAPS);
    localparam int SUM_W  = DATA_W + LOG2_T;
    localparam int CNT_W  = (clog2_f(ROW_LEN) > 0) ? clog2_f(ROW_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_LEN - 1);

    // Sum is wide enough that adding TAPS/2 cannot wrap, and the result always fits DATA_W.
    function automatic logic [DATA_W-1:0] mean_f(input logic [SUM_W-1:0] s);
`ifdef SMOOTH_ROUND_EN
        logic [SUM_W-1:0] r;
        r = s + SUM_W'(TAPS / 2);
        return r[SUM_W-1:LOG2_T];
`else
        return s[SUM_W-1:LOG2_T];
`endif
    endfunction

    smooth_state_e     state_q, state_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              accept, fill, shift, last_d;
    logic [DATA_W-1:0] oldest;

    assign accept = enb & in_valid;

    smooth_tap_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_tap_line (
        .clk      (clk),
        .reset    (reset),
        .fill_i   (fill),
        .shift_i  (shift),
        .din_i    (in_data),
        .oldest_o (oldest)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        sum_d   = sum_q;
        fill    = 1'b0;
        shift   = 1'b0;
        if (accept) begin
            case (state_q)
                ROW_START: begin
                    fill    = 1'b1;
                    col_d   = '0;
                    sum_d   = SUM_W'(in_data) << LOG2_T;
                    state_d = (LAST_COL == '0) ? ROW_START : IN_ROW;
                end
                IN_ROW: begin
                    shift = 1'b1;
                    col_d = col_q + CNT_W'(1);
                    sum_d = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
                    if (col_d == LAST_COL) begin
                        state_d = ROW_START;
                    end
                end
                default: state_d = ROW_START;
            endcase
        end
        last_d = (col_d == LAST_COL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ROW_START;
            col_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (enb) begin
            state_q     <= state_d;
            col_q       <= col_d;
            sum_q       <= sum_d;
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_data_q <= mean_f(sum_d);
                out_last_q <= last_d;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_row_smoothing_filter.sv
// Self-checking bench for row_smoothing_filter: table vectors, directed row scenarios, random run.
module tb_row_smoothing_filter;

    localparam int DATA_W  = 8;
    localparam int TAPS    = 4;
    localparam int ROW_LEN = 150;
`ifdef SMOOTH_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, enb, in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    int checks = 0;
    int errors = 0;

    int row_q[$];
    int exp_data = 0;
    bit exp_last = 1'b0;
    int cap_q[$];

    row_smoothing_filter #(
        .DATA_W  (DATA_W),
        .TAPS    (TAPS),
        .ROW_LEN (ROW_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Mean of the last TAPS samples of the current row, positions before column 0 clamped.
    function automatic int model_mean();
        int s, idx, n;
        s = 0;
        n = row_q.size();
        for (int k = 0; k < TAPS; k++) begin
            idx = n - 1 - k;
            s += (idx < 0) ? row_q[0] : row_q[idx];
        end
        if (RND) s += TAPS / 2;
        return s / TAPS;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit v, input int d);
        reset    = r;
        enb      = e;
        in_valid = v;
        in_data  = d[DATA_W-1:0];
        @(posedge clk);
        #1;
        if (r) begin
            row_q.delete();
            exp_data = 0;
            exp_last = 1'b0;
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_data", int'(out_data), 0);
            chk("rst_last", int'(out_last), 0);
        end else if (e && v) begin
            row_q.push_back(d);
            exp_data = model_mean();
            exp_last = (row_q.size() == ROW_LEN);
            if (exp_last) row_q.delete();
            chk("out_valid", int'(out_valid), 1);
            chk("out_data", int'(out_data), exp_data);
            chk("out_last", int'(out_last), int'(exp_last));
            cap_q.push_back(int'(out_data));
        end else begin
            chk("idle_valid", int'(out_valid), 0);
            if (!e) begin
                chk("stall_data_hold", int'(out_data), exp_data);
                chk("stall_last_hold", int'(out_last), int'(exp_last));
            end
        end
    endtask

    typedef struct {
        bit rst_before;
        int din;
        int exp_t;
        int exp_r;
    } vec_t;

    vec_t tbl[8];
    int   ref_q[$];
    int   gap_data[20];
    int   last_cnt;

    initial begin
        tbl[0] = '{1'b1, 0,   0,   0};
        tbl[1] = '{1'b0, 200, 50,  50};
        tbl[2] = '{1'b0, 200, 100, 100};
        tbl[3] = '{1'b0, 200, 150, 150};
        tbl[4] = '{1'b0, 200, 200, 200};
        tbl[5] = '{1'b1, 0,   0,   0};
        tbl[6] = '{1'b0, 1,   0,   0};
        tbl[7] = '{1'b0, 1,   0,   1};

        reset = 1'b1; enb = 1'b0; in_valid = 1'b0; in_data = '0;
        cyc(1, 1, 1, 77);
        cyc(1, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst_before) cyc(1, 0, 0, 0);
            cyc(0, 1, 1, tbl[i].din);
            chk($sformatf("table_%0d", i), int'(out_data), RND ? tbl[i].exp_r : tbl[i].exp_t);
        end

        // Full row of a constant: out_last only on the 150th output.
        cyc(1, 0, 0, 0);
        last_cnt = 0;
        for (int i = 0; i < ROW_LEN; i++) begin
            cyc(0, 1, 1, 100);
            chk("const_data", int'(out_data), 100);
            if (out_last) last_cnt++;
        end
        chk("const_last_count", last_cnt, 1);
        chk("const_last_final", int'(out_last), 1);

        // Row of 255 followed by a row starting at 0: no carry-over.
        for (int i = 0; i < ROW_LEN; i++) cyc(0, 1, 1, 255);
        cyc(0, 1, 1, 0);
        chk("row2_first", int'(out_data), 0);
        cyc(0, 1, 1, 0);
        chk("row2_second", int'(out_data), 0);

        // Reset mid-row then a complete row of 10.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 71; i++) cyc(0, 1, 1, $urandom_range(0, 255));
        cyc(1, 1, 1, 200);
        cyc(1, 1, 0, 0);
        last_cnt = 0;
        for (int i = 0; i < ROW_LEN; i++) begin
            cyc(0, 1, 1, 10);
            chk("after_rst_data", int'(out_data), 10);
            if (out_last) last_cnt++;
        end
        chk("after_rst_last_count", last_cnt, 1);
        chk("after_rst_last_final", int'(out_last), 1);

        // Stalls and gaps must not change the output sequence.
        for (int i = 0; i < 20; i++) gap_data[i] = $urandom_range(0, 255);
        cyc(1, 0, 0, 0);
        cap_q.delete();
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, gap_data[i]);
        ref_q = cap_q;
        cyc(1, 0, 0, 0);
        cap_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 6) for (int j = 0; j < 5; j++) cyc(0, 0, 1, 255);
            if (i == 11) begin
                cyc(0, 1, 0, 255);
                cyc(0, 1, 0, 0);
            end
            cyc(0, 1, 1, gap_data[i]);
        end
        chk("gap_count", cap_q.size(), 20);
        for (int i = 0; i < 20 && i < cap_q.size(); i++) begin
            chk($sformatf("gap_seq_%0d", i), cap_q[i], ref_q[i]);
        end

        // Random traffic with occasional stalls, gaps and resets across row wraps.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 4) != 0), $urandom_range(0, 255));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_smoothing_filter.md
ROW_SMOOTHING_FILTER -- requirements
Module: row_smoothing_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter TAPS, default 4, meaning window length; a power of two from 2 to 16.
REQ-003 SHALL have parameter ROW_LEN, default 150, meaning pixels per image row.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic acts on the rising edge.
REQ-005 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port enb  input  1  meaning block enable; when low, all state holds.
REQ-007 SHALL have port in_valid  input  1  meaning in_data is valid this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  meaning input pixel, unsigned.
REQ-009 SHALL have port out_valid  output  1  meaning out_data is valid this cycle.
REQ-010 SHALL have port out_data  output  DATA_W  meaning smoothed pixel, unsigned.
REQ-011 SHALL have port out_last  output  1  meaning out_data is the last pixel of a row.

Function
REQ-012 A sample SHALL be accepted in any cycle where enb=1 and in_valid=1; there is no backpressure.
REQ-013 out_valid SHALL be asserted exactly one cycle after each accepted sample (latency 1), and SHALL be low otherwise.
REQ-014 out_data SHALL be the mean of the last TAPS accepted samples of the current row, the newest included.
REQ-015 Window positions before column 0 SHALL take the value of the row's column-0 pixel (edge clamp); no sample from a previous row SHALL contribute.
REQ-016 Mean SHALL be sum >> log2(TAPS); the sum register SHALL be DATA_W+log2(TAPS) bits wide, so no overflow or saturation occurs.
REQ-017 The sum SHALL be updated as a running sum (add newest, subtract oldest), not by re-adding the whole window.
REQ-018 A column counter SHALL count accepted samples from 0 to ROW_LEN-1 and then wrap to 0.
REQ-019 out_last SHALL be asserted with the output for column ROW_LEN-1.
REQ-020 The FSM SHALL have states ROW_START and IN_ROW.
REQ-021 In ROW_START, an accepted sample SHALL fill every window slot with that sample, set the column to 0 and move to IN_ROW.
REQ-022 In IN_ROW, an accepted sample SHALL shift the window and increment the column.
REQ-023 In IN_ROW, the sample accepted at column ROW_LEN-1 SHALL return the FSM to ROW_START.
REQ-024 With enb=0, the FSM, counter, window and sum SHALL hold, out_valid SHALL be 0, and out_data/out_last SHALL hold.
REQ-025 Gaps in in_valid SHALL neither shift the window nor advance the column.

Reset
REQ-026 reset=1 SHALL set, on the next rising edge: FSM to ROW_START, column 0, window and sum 0, out_valid 0, out_data 0, out_last 0.
REQ-027 reset SHALL take priority over enb and in_valid; a sample presented in a reset cycle SHALL be discarded.
REQ-028 Reset mid-row SHALL abandon the partial row; the next accepted sample SHALL be column 0.

Configuration
REQ-029 With macro SMOOTH_ROUND_EN defined, mean SHALL be (sum + TAPS/2) >> log2(TAPS) (round half up); with it undefined, mean SHALL truncate per REQ-016.
REQ-030 Rounding SHALL add no latency and SHALL never overflow DATA_W.

Structure
REQ-031 Package smooth_pkg SHALL hold the FSM state typedef (ROW_START, IN_ROW) and a log2 constant function used for sum and counter widths.
REQ-032 The TAPS-deep pixel delay line with parallel fill SHALL be sub-module smooth_tap_line; the sum, counter and FSM SHALL stay in row_smoothing_filter.

Verification (DATA_W=8, TAPS=4, ROW_LEN=150 unless stated)
REQ-033 Constant 100 on 150 consecutive cycles -> out_data=100 on every output, out_valid one cycle after each in_valid, out_last only on the 150th output.
REQ-034 Row starts 0, then 200,200,200,200 -> outputs 0,50,100,150,200.
REQ-035 Row 1 all 255, row 2 column 0 = 0 -> row 2 first output 0, with no carry-over from row 1.
REQ-036 Row 0,1,1 -> third output 0 with SMOOTH_ROUND_EN undefined, 1 with it defined.
REQ-037 reset pulsed after column 70, then 150 samples of 10 -> outputs 0 during reset, then 150 outputs of 10, out_last on the 150th.
REQ-038 enb=0 for 5 cycles and in_valid gaps inside a row -> no out_valid during the stall or gap, and the output sequence matches the gap-free run.
